// File: rtl/alarm_timer.sv
// Countdown timer and four-slot delay store for the anti-theft alarm FSM.
// Derives a one-second enable from the system clock and pulses `expired` when the selected delay runs out.
module alarm_timer #(
    parameter int CLK_DIVIDE    = 27000000,
    parameter int DEF_ARM       = 6,
    parameter int DEF_DRIVER    = 8,
    parameter int DEF_PASSENGER = 15,
    parameter int DEF_ALARM     = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       prog_sync,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic       busy,
    output logic [3:0] remaining,
    output logic       one_hz_enable,
    output logic [3:0] param_readback
);

    localparam int DW = $clog2(CLK_DIVIDE);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIVIDE - 1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_store [4];
    logic [DW-1:0] r_div;
    logic [3:0]  r_remaining;
    logic [3:0]  w_nextRemaining;
    logic        r_expired;
    logic        w_nextExpired;
    logic [3:0]  w_startValue;
    logic        w_tick;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_store[0] <= 4'(DEF_ARM);
            r_store[1] <= 4'(DEF_DRIVER);
            r_store[2] <= 4'(DEF_PASSENGER);
            r_store[3] <= 4'(DEF_ALARM);
        end else if (prog_sync) begin
            r_store[time_param_sel] <= time_value;
        end
    end

    // A start realigns the divider so the first decrement lands a full second later.
    always_ff @(posedge clock) begin
        if (reset || start_timer || (r_div == DIV_MAX)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_tick = (r_div == DIV_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= 4'd0;
            r_expired   <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_remaining <= w_nextRemaining;
            r_expired   <= w_nextExpired;
        end
    end

    // The start value comes from the registered store, so a same-cycle write only affects later starts.
    always_comb begin
        w_nextState     = r_state;
        w_nextRemaining = r_remaining;
        w_nextExpired   = 1'b0;
        w_startValue    = r_store[interval];
        if (start_timer) begin
            if (w_startValue != 4'd0) begin
                w_nextRemaining = w_startValue;
                w_nextState     = COUNT;
            end else begin
                w_nextRemaining = 4'd0;
                w_nextState     = IDLE;
                w_nextExpired   = 1'b1;
            end
        end else if ((r_state == COUNT) && w_tick) begin
            w_nextRemaining = r_remaining - 4'd1;
            if (r_remaining == 4'd1) begin
                w_nextState   = IDLE;
                w_nextExpired = 1'b1;
            end
        end
    end

    assign expired        = r_expired;
    assign busy           = (r_state == COUNT);
    assign remaining      = r_remaining;
    assign one_hz_enable  = w_tick;
    assign param_readback = r_store[time_param_sel];

endmodule

// File: tb/tb_alarm_timer.sv
// Directed self-checking bench for alarm_timer with a 4-cycle second.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alarm_timer;

    logic       clock;
    logic       reset;
    logic       start_timer;
    logic [1:0] interval;
    logic       prog_sync;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       expired;
    logic       busy;
    logic [3:0] remaining;
    logic       one_hz_enable;
    logic [3:0] param_readback;

    int errors = 0;
    int checks = 0;

    alarm_timer #(
        .CLK_DIVIDE(4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start_timer   (start_timer),
        .interval      (interval),
        .prog_sync     (prog_sync),
        .time_param_sel(time_param_sel),
        .time_value    (time_value),
        .expired       (expired),
        .busy          (busy),
        .remaining     (remaining),
        .one_hz_enable (one_hz_enable),
        .param_readback(param_readback)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Returns just after the edge that sampled the start request.
    task automatic applyStimulus(input logic [1:0] slot);
        interval    = slot;
        start_timer = 1'b1;
        stepCycle();
        start_timer = 1'b0;
    endtask

    initial begin
        logic sawExpired;
        logic foundTick;
        int   defs [4];
        defs = '{6, 8, 15, 10};

        reset          = 1'b1;
        start_timer    = 1'b0;
        interval       = 2'd0;
        prog_sync      = 1'b0;
        time_param_sel = 2'd0;
        time_value     = 4'd0;
        stepCycle();
        stepCycle();

        checkOutput("reset_expired", 32'(expired), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_remaining", 32'(remaining), 32'd0);
        checkOutput("reset_one_hz", 32'(one_hz_enable), 32'd0);
        for (int s = 0; s < 4; s++) begin
            time_param_sel = 2'(s);
            #1;
            checkOutput("reset_readback", 32'(param_readback), 32'(defs[s]));
        end
        reset = 1'b0;
        stepCycle();

        // Slot 0, 6 s: 24 cycles of busy, decrement every fourth edge.
        applyStimulus(2'd0);
        checkOutput("t1_busy_start", 32'(busy), 32'd1);
        checkOutput("t1_rem_start", 32'(remaining), 32'd6);
        for (int j = 1; j <= 24; j++) begin
            stepCycle();
            checkOutput("t1_expired", 32'(expired), 32'(j == 24));
            checkOutput("t1_busy", 32'(busy), 32'(j < 24));
            checkOutput("t1_remaining", 32'(remaining), 32'(6 - j / 4));
            checkOutput("t1_one_hz", 32'(one_hz_enable), 32'((j % 4) == 3));
        end
        stepCycle();
        checkOutput("t1_expired_width", 32'(expired), 32'd0);
        checkOutput("t1_remaining_hold", 32'(remaining), 32'd0);

        // Program slot 2 to 3 s.
        prog_sync      = 1'b1;
        time_param_sel = 2'd2;
        time_value     = 4'd3;
        stepCycle();
        prog_sync = 1'b0;
        checkOutput("t2_readback", 32'(param_readback), 32'd3);
        applyStimulus(2'd2);
        for (int j = 1; j <= 14; j++) begin
            stepCycle();
            checkOutput("t2_expired", 32'(expired), 32'(j == 12));
        end

        // Zero delay expires on the next cycle without ever going busy.
        prog_sync      = 1'b1;
        time_param_sel = 2'd1;
        time_value     = 4'd0;
        stepCycle();
        prog_sync = 1'b0;
        checkOutput("t3_readback", 32'(param_readback), 32'd0);
        applyStimulus(2'd1);
        checkOutput("t3_expired", 32'(expired), 32'd1);
        checkOutput("t3_busy", 32'(busy), 32'd0);
        checkOutput("t3_remaining", 32'(remaining), 32'd0);
        stepCycle();
        checkOutput("t3_expired_width", 32'(expired), 32'd0);
        checkOutput("t3_busy_after", 32'(busy), 32'd0);

        // Slot 3 (10 s) aborted by a slot 0 restart on the ninth edge.
        applyStimulus(2'd3);
        checkOutput("t4_rem_start", 32'(remaining), 32'd10);
        for (int j = 1; j <= 8; j++) begin
            stepCycle();
            checkOutput("t4_expired_pre", 32'(expired), 32'd0);
        end
        checkOutput("t4_rem_before_restart", 32'(remaining), 32'd8);
        applyStimulus(2'd0);
        checkOutput("t4_rem_restart", 32'(remaining), 32'd6);
        checkOutput("t4_busy_restart", 32'(busy), 32'd1);
        for (int j = 10; j <= 45; j++) begin
            stepCycle();
            checkOutput("t4_expired", 32'(expired), 32'(j == 33));
        end

        // Reset mid-count, with modified slots, restores everything.
        applyStimulus(2'd0);
        for (int j = 1; j <= 9; j++) stepCycle();
        checkOutput("t5_rem_before_reset", 32'(remaining), 32'd4);
        reset = 1'b1;
        stepCycle();
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_remaining", 32'(remaining), 32'd0);
        checkOutput("t5_expired", 32'(expired), 32'd0);
        for (int s = 0; s < 4; s++) begin
            time_param_sel = 2'(s);
            #1;
            checkOutput("t5_readback", 32'(param_readback), 32'(defs[s]));
        end
        reset      = 1'b0;
        sawExpired = 1'b0;
        for (int j = 0; j < 30; j++) begin
            stepCycle();
            if (expired !== 1'b0) sawExpired = 1'b1;
        end
        checkOutput("t5_no_expired", 32'(sawExpired), 32'd0);

        // Same-cycle write and start on slot 0: old value for this run, new value later.
        prog_sync      = 1'b1;
        time_param_sel = 2'd0;
        time_value     = 4'd2;
        applyStimulus(2'd0);
        prog_sync = 1'b0;
        checkOutput("t6_rem_start", 32'(remaining), 32'd6);
        checkOutput("t6_readback", 32'(param_readback), 32'd2);
        for (int j = 1; j <= 24; j++) begin
            stepCycle();
            checkOutput("t6_expired_old", 32'(expired), 32'(j == 24));
        end
        stepCycle();
        applyStimulus(2'd0);
        checkOutput("t6_rem_new", 32'(remaining), 32'd2);
        for (int j = 1; j <= 10; j++) begin
            stepCycle();
            checkOutput("t6_expired_new", 32'(expired), 32'(j == 8));
        end

        // Start coinciding with a tick: the start wins and no decrement happens.
        applyStimulus(2'd3);
        foundTick = 1'b0;
        for (int j = 0; j < 8 && !foundTick; j++) begin
            stepCycle();
            if (one_hz_enable === 1'b1) foundTick = 1'b1;
        end
        checkOutput("t7_tick_found", 32'(foundTick), 32'd1);
        checkOutput("t7_rem_before", 32'(remaining), 32'd10);
        applyStimulus(2'd2);
        checkOutput("t7_rem_start_on_tick", 32'(remaining), 32'd15);
        checkOutput("t7_expired_none", 32'(expired), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
